// File: rtl/layer_sched.sv
// layer_sched: runs one FC layer neuron by neuron on the dot engine; 9 cycles per unstalled neuron plus 1 DONE cycle.
// CPU accesses stall while busy, eng_* are held under eng_waitrequest; LAYER_SCHED_CHECKSUM_EN adds a result checksum at offset 8.
module layer_sched (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        eng_waitrequest,
    output logic [3:0]  eng_address,
    output logic        eng_read,
    input  logic [31:0] eng_readdata,
    output logic        eng_write,
    output logic [31:0] eng_writedata
);
    typedef enum logic [2:0] {S_IDLE, S_CFG, S_GO, S_WAIT, S_NEXT, S_DONE} state_t;

    typedef struct packed {
        logic [31:0] bias;
        logic [31:0] wgt;
        logic [31:0] inp;
        logic [31:0] n_in;
        logic [31:0] outp;
        logic [31:0] n_out;
        logic        relu;
    } cfg_t;

    state_t      state_q, state_d;
    cfg_t        cfg_q, cfg_d;
    cfg_t        wk_q, wk_d;    // start snapshot; bias/wgt/outp double as the working pointers
    logic [2:0]  idx_q, idx_d;
    logic [31:0] k_q, k_d;
    logic [31:0] done_cnt_q, done_cnt_d;
    logic [3:0]  eng_address_q, eng_address_d;
    logic [31:0] eng_writedata_q, eng_writedata_d;
    logic        eng_write_q, eng_write_d;
    logic        eng_read_q, eng_read_d;
    logic        busy, cpu_wr, start, eng_acc, res_acc;
    logic [31:0] csum_rd;

    assign busy              = (state_q != S_IDLE);
    assign slave_waitrequest = busy & (slave_read | slave_write);
    assign cpu_wr            = slave_write & ~busy;
    assign start             = cpu_wr & (slave_address == 4'd0);
    assign eng_acc           = (eng_write_q | eng_read_q) & ~eng_waitrequest;
    assign res_acc           = (state_q == S_WAIT) & eng_acc;

    assign eng_address   = eng_address_q;
    assign eng_writedata = eng_writedata_q;
    assign eng_write     = eng_write_q;
    assign eng_read      = eng_read_q;

`ifdef LAYER_SCHED_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start)
            csum_d = '0;
        else if (res_acc)
            csum_d = csum_q + eng_readdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_d;
    end

    assign csum_rd = csum_q;
`else
    logic unused_rdat;
    assign unused_rdat = ^eng_readdata;
    assign csum_rd     = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cfg_q           <= '0;
            wk_q            <= '0;
            idx_q           <= '0;
            k_q             <= '0;
            done_cnt_q      <= '0;
            eng_address_q   <= '0;
            eng_writedata_q <= '0;
            eng_write_q     <= 1'b0;
            eng_read_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cfg_q           <= cfg_d;
            wk_q            <= wk_d;
            idx_q           <= idx_d;
            k_q             <= k_d;
            done_cnt_q      <= done_cnt_d;
            eng_address_q   <= eng_address_d;
            eng_writedata_q <= eng_writedata_d;
            eng_write_q     <= eng_write_d;
            eng_read_q      <= eng_read_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (cfg_q.n_out != 32'd0) ? S_CFG : S_DONE;
            S_CFG:  if (eng_acc && idx_q == 3'd5) state_d = S_GO;
            S_GO:   if (eng_acc) state_d = S_WAIT;
            S_WAIT: if (eng_acc) state_d = S_NEXT;
            S_NEXT: state_d = (k_q + 32'd1 == wk_q.n_out) ? S_DONE : S_CFG;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_d      = cfg_q;
        wk_d       = wk_q;
        idx_d      = idx_q;
        k_d        = k_q;
        done_cnt_d = done_cnt_q;
        if (cpu_wr) begin
            case (slave_address)
                4'd1: cfg_d.bias  = slave_writedata;
                4'd2: cfg_d.wgt   = slave_writedata;
                4'd3: cfg_d.inp   = slave_writedata;
                4'd4: cfg_d.n_in  = slave_writedata;
                4'd5: cfg_d.outp  = slave_writedata;
                4'd6: cfg_d.n_out = slave_writedata;
                4'd7: cfg_d.relu  = slave_writedata[0];
                default: ;
            endcase
        end
        if (start) begin
            wk_d       = cfg_q;
            idx_d      = '0;
            k_d        = '0;
            done_cnt_d = '0;
        end
        if (state_q == S_CFG && eng_acc)
            idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        if (res_acc) begin
            done_cnt_d = done_cnt_q + 32'd1;
            wk_d.wgt   = wk_q.wgt + {wk_q.n_in[29:0], 2'b00};
            wk_d.bias  = wk_q.bias + 32'd4;
            wk_d.outp  = wk_q.outp + 32'd4;
        end
        if (state_q == S_NEXT && state_d == S_CFG)
            k_d = k_q + 32'd1;
    end

    // Engine outputs are a registered function of the next state, so they hold while stalled.
    always_comb begin
        eng_address_d   = '0;
        eng_writedata_d = '0;
        eng_write_d     = 1'b0;
        eng_read_d      = 1'b0;
        case (state_d)
            S_CFG: begin
                eng_write_d = 1'b1;
                case (idx_d)
                    3'd0: begin eng_address_d = 4'd1; eng_writedata_d = wk_d.bias; end
                    3'd1: begin eng_address_d = 4'd2; eng_writedata_d = wk_d.wgt;  end
                    3'd2: begin eng_address_d = 4'd3; eng_writedata_d = wk_d.inp;  end
                    3'd3: begin eng_address_d = 4'd4; eng_writedata_d = wk_d.n_in; end
                    3'd4: begin eng_address_d = 4'd5; eng_writedata_d = wk_d.outp; end
                    default: begin eng_address_d = 4'd7; eng_writedata_d = {31'b0, wk_d.relu}; end
                endcase
            end
            S_GO:    eng_write_d = 1'b1;
            S_WAIT:  eng_read_d  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        slave_readdata = '0;
        if (slave_read) begin
            case (slave_address)
                4'd0: slave_readdata = done_cnt_q;
                4'd1: slave_readdata = cfg_q.bias;
                4'd2: slave_readdata = cfg_q.wgt;
                4'd3: slave_readdata = cfg_q.inp;
                4'd4: slave_readdata = cfg_q.n_in;
                4'd5: slave_readdata = cfg_q.outp;
                4'd6: slave_readdata = cfg_q.n_out;
                4'd7: slave_readdata = {31'b0, cfg_q.relu};
                4'd8: slave_readdata = csum_rd;
                default: slave_readdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: register table, engine transaction table, stall/reset/checksum sequences.
`timescale 1ns/1ps
module tb_layer_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = '0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = '0;
    logic        eng_waitrequest = 1'b0;
    logic [3:0]  eng_address;
    logic        eng_read;
    logic [31:0] eng_readdata = '0;
    logic        eng_write;
    logic [31:0] eng_writedata;

    layer_sched dut (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
        .slave_read(slave_read), .slave_readdata(slave_readdata),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .eng_waitrequest(eng_waitrequest), .eng_address(eng_address),
        .eng_read(eng_read), .eng_readdata(eng_readdata),
        .eng_write(eng_write), .eng_writedata(eng_writedata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] addr; logic [31:0] wdat; logic [31:0] exp; } reg_vec_t;
    typedef struct { logic [3:0] addr; logic [31:0] dat; logic rd; } eng_vec_t;

    reg_vec_t    rv [0:10];
    eng_vec_t    ev [0:23];
    int          checks = 0;
    int          failures = 0;

    logic [3:0]  lg_addr [0:63];
    logic [31:0] lg_data [0:63];
    logic        lg_rd   [0:63];
    int          log_n = 0;
    logic [31:0] results [0:7];
    int          res_idx = 0;
    bit          stall_en = 1'b0;
    bit          in_txn = 1'b0;
    int          stall_left = 0;
    logic [3:0]  s_addr;
    logic [31:0] s_data;
    logic [1:0]  s_strb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Engine slave model: optional random stall per transaction, logs each accepted transaction.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_txn = 1'b0;
            eng_waitrequest = 1'b0;
        end else if (eng_write || eng_read) begin
            if (!in_txn) begin
                in_txn     = 1'b1;
                stall_left = stall_en ? int'($urandom_range(5, 0)) : 0;
                s_addr     = eng_address;
                s_data     = eng_writedata;
                s_strb     = {eng_write, eng_read};
            end else begin
                check("stall_addr", {28'b0, eng_address}, {28'b0, s_addr});
                check("stall_data", eng_writedata, s_data);
                check("stall_strobe", {30'b0, eng_write, eng_read}, {30'b0, s_strb});
            end
            if (stall_left > 0) begin
                eng_waitrequest = 1'b1;
                stall_left--;
            end else begin
                eng_waitrequest = 1'b0;
                in_txn = 1'b0;
                if (log_n < 64) begin
                    lg_addr[log_n] = eng_address;
                    lg_data[log_n] = eng_writedata;
                    lg_rd[log_n]   = eng_read;
                end
                log_n++;
                if (eng_read) begin
                    eng_readdata = results[res_idx % 8];
                    res_idx++;
                end
            end
        end else begin
            eng_waitrequest = 1'b0;
            in_txn = 1'b0;
        end
    end

    task automatic cpu_write(input logic [3:0] a, input logic [31:0] d, output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!slave_waitrequest) begin ok = 1'b1; break; end
            stalls++;
        end
        @(posedge clk); #1;
        slave_write = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL cpu_write_timeout: addr %0d still stalled after %0d cycles, expected completion", a, stalls);
        end
    endtask

    task automatic cpu_read(input logic [3:0] a, output logic [31:0] d, output int stalls);
        bit ok;
        ok = 1'b0;
        stalls = 0;
        d = '0;
        slave_address = a; slave_read = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!slave_waitrequest) begin ok = 1'b1; d = slave_readdata; break; end
            stalls++;
        end
        @(posedge clk); #1;
        slave_read = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL cpu_read_timeout: addr %0d still stalled after %0d cycles, expected completion", a, stalls);
        end
    endtask

    task automatic program_layer();
        int st;
        for (int i = 0; i < 11; i++) cpu_write(rv[i].addr, rv[i].wdat, st);
    endtask

    task automatic check_log(input string tag);
        check({tag, "_txn_count"}, log_n, 24);
        for (int i = 0; i < 24; i++) begin
            check($sformatf("%s_addr%0d", tag, i), {28'b0, lg_addr[i]}, {28'b0, ev[i].addr});
            check($sformatf("%s_rd%0d", tag, i), {31'b0, lg_rd[i]}, {31'b0, ev[i].rd});
            if (!ev[i].rd) check($sformatf("%s_data%0d", tag, i), lg_data[i], ev[i].dat);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_slave_wait"}, {31'b0, slave_waitrequest}, 32'd0);
        check({tag, "_slave_rdata"}, slave_readdata, 32'd0);
        check({tag, "_eng_strobes"}, {30'b0, eng_write, eng_read}, 32'd0);
        check({tag, "_eng_addr"}, {28'b0, eng_address}, 32'd0);
        check({tag, "_eng_wdata"}, eng_writedata, 32'd0);
    endtask

    task automatic check_regs_zero(input string tag);
        logic [31:0] rd;
        int st;
        for (int a = 0; a <= 8; a++) begin
            cpu_read(4'(a), rd, st);
            check($sformatf("%s_reg%0d", tag, a), rd, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int st;
        bit found;
        logic [31:0] exp_csum;

        rv[0]  = '{4'd12, 32'hDEAD_BEEF, 32'h0};
        rv[1]  = '{4'd8,  32'h0000_0077, 32'h0};
        rv[2]  = '{4'd9,  32'h0000_0001, 32'h0};
        rv[3]  = '{4'd15, 32'hFFFF_FFFF, 32'h0};
        rv[4]  = '{4'd1,  32'h0000_2000, 32'h0000_2000};
        rv[5]  = '{4'd2,  32'h0000_1000, 32'h0000_1000};
        rv[6]  = '{4'd3,  32'h0000_3000, 32'h0000_3000};
        rv[7]  = '{4'd4,  32'h0000_0004, 32'h0000_0004};
        rv[8]  = '{4'd5,  32'h0000_4000, 32'h0000_4000};
        rv[9]  = '{4'd6,  32'h0000_0003, 32'h0000_0003};
        rv[10] = '{4'd7,  32'h0000_0001, 32'h0000_0001};
        for (int n = 0; n < 3; n++) begin
            ev[n*8+0] = '{4'd1, 32'h2000 + 32'(4*n),  1'b0};
            ev[n*8+1] = '{4'd2, 32'h1000 + 32'(16*n), 1'b0};
            ev[n*8+2] = '{4'd3, 32'h3000,             1'b0};
            ev[n*8+3] = '{4'd4, 32'd4,                1'b0};
            ev[n*8+4] = '{4'd5, 32'h4000 + 32'(4*n),  1'b0};
            ev[n*8+5] = '{4'd7, 32'd1,                1'b0};
            ev[n*8+6] = '{4'd0, 32'd0,                1'b0};
            ev[n*8+7] = '{4'd0, 32'd0,                1'b1};
        end
        results[0] = 32'd10; results[1] = 32'd20; results[2] = 32'd30;
        for (int i = 3; i < 8; i++) results[i] = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_regs_zero("reset");

        // Register map: write then read back every vector
        for (int i = 0; i < 11; i++) begin
            cpu_write(rv[i].addr, rv[i].wdat, st);
            check($sformatf("idle_wr_stall%0d", i), st, 0);
            cpu_read(rv[i].addr, rd, st);
            check($sformatf("regmap_off%0d", rv[i].addr), rd, rv[i].exp);
        end

        // Nominal layer, no stalls
        log_n = 0; res_idx = 0;
        cpu_write(4'd0, 32'd1, st);
        cpu_read(4'd0, rd, st);
        check("layer_done_count", rd, 32'd3);
        check("layer_cycles", st, 28);
        check_log("layer");
`ifdef LAYER_SCHED_CHECKSUM_EN
        exp_csum = 32'd60;
`else
        exp_csum = 32'd0;
`endif
        cpu_read(4'd8, rd, st);
        check("layer_checksum", rd, exp_csum);

        // Same layer with random engine stalls
        stall_en = 1'b1;
        log_n = 0; res_idx = 0;
        cpu_write(4'd0, 32'd1, st);
        cpu_read(4'd0, rd, st);
        check("stall_done_count", rd, 32'd3);
        check_log("stall");
        stall_en = 1'b0;

        // n_out = 0: no engine traffic, DONE then IDLE
        cpu_write(4'd6, 32'd0, st);
        log_n = 0;
        cpu_write(4'd0, 32'd1, st);
        cpu_read(4'd0, rd, st);
        check("nout0_count", rd, 32'd0);
        check("nout0_stall", st, 1);
        check("nout0_traffic", log_n, 0);
        cpu_write(4'd6, 32'd3, st);

        // Config write while busy stalls to IDLE and does not disturb the layer
        log_n = 0; res_idx = 0;
        cpu_write(4'd0, 32'd1, st);
        cpu_write(4'd2, 32'h5000, st);
        check("busy_wr_stall", st, 28);
        check_log("busy_wr");
        cpu_read(4'd2, rd, st);
        check("busy_wr_readback", rd, 32'h5000);
        cpu_write(4'd2, 32'h1000, st);

        // Reset during WAIT of the second neuron
        log_n = 0; res_idx = 0;
        cpu_write(4'd0, 32'd1, st);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #2;
            if (eng_read && log_n >= 15) begin found = 1'b1; break; end
        end
        check("rst_wait_reached", {31'b0, found}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_regs_zero("midrst");
        program_layer();
        log_n = 0; res_idx = 0;
        cpu_write(4'd0, 32'd1, st);
        cpu_read(4'd0, rd, st);
        check("rerun_done_count", rd, 32'd3);
        check("rerun_cycles", st, 28);
        check_log("rerun");

        // Checksum wrap
        results[0] = 32'hFFFF_FFFF; results[1] = 32'h2;
        cpu_write(4'd6, 32'd2, st);
        log_n = 0; res_idx = 0;
        cpu_write(4'd0, 32'd1, st);
        cpu_read(4'd0, rd, st);
        check("csum_done_count", rd, 32'd2);
        check("csum_cycles", st, 19);
        cpu_read(4'd8, rd, st);
`ifdef LAYER_SCHED_CHECKSUM_EN
        check("csum_wrap", rd, 32'h1);
`else
        check("csum_absent", rd, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
